// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - D-stage stall and E/M/W forwarding control from Tuse/Tnew shadow records.
// Optional stall performance counter enabled by defining HAZ_PERF_CNT_EN.
module hazard_scheduler #(
    parameter int RA_W   = 5,
    parameter int T_W    = 2,
    parameter int PCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RA_W-1:0]   d_rs,
    input  logic [RA_W-1:0]   d_rt,
    input  logic [T_W-1:0]    d_tuse_rs,
    input  logic [T_W-1:0]    d_tuse_rt,
    input  logic [RA_W-1:0]   d_a3,
    input  logic [T_W-1:0]    d_tnew,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic [PCNT_W-1:0] stall_cnt
);

    localparam logic [T_W-1:0] T_ZERO   = '0;
    localparam logic [T_W-1:0] T_ONE    = {{(T_W-1){1'b0}}, 1'b1};
    localparam logic [T_W-1:0] T_UNUSED = '1;

    logic [RA_W-1:0] r_e_a3, r_e_rs, r_e_rt, r_m_a3, r_w_a3;
    logic [T_W-1:0]  r_e_tnew, r_m_tnew, r_w_tnew;
    logic            w_stall;

    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == T_ZERO) ? T_ZERO : t - T_ONE;
    endfunction

    function automatic logic match(input logic [RA_W-1:0] x, input logic [RA_W-1:0] a3);
        return (x != '0) && (x == a3);
    endfunction

    function automatic logic hazard(input logic [RA_W-1:0] x, input logic [T_W-1:0] tuse,
                                    input logic [RA_W-1:0] a3, input logic [T_W-1:0] tnew);
        return match(x, a3) && (tuse != T_UNUSED) && (tuse < tnew);
    endfunction

    // Youngest matching producer decides; if it is not ready yet, select the regfile path.
    function automatic logic [1:0] sel_d(input logic [RA_W-1:0] x,
                                         input logic [RA_W-1:0] ea3, input logic [T_W-1:0] et,
                                         input logic [RA_W-1:0] ma3, input logic [T_W-1:0] mt,
                                         input logic [RA_W-1:0] wa3, input logic [T_W-1:0] wt);
        if (match(x, ea3)) return (et == T_ZERO) ? 2'd1 : 2'd0;
        if (match(x, ma3)) return (mt == T_ZERO) ? 2'd2 : 2'd0;
        if (match(x, wa3)) return (wt == T_ZERO) ? 2'd3 : 2'd0;
        return 2'd0;
    endfunction

    always_comb begin
        w_stall  = hazard(d_rs, d_tuse_rs, r_e_a3, r_e_tnew) ||
                   hazard(d_rs, d_tuse_rs, r_m_a3, r_m_tnew) ||
                   hazard(d_rt, d_tuse_rt, r_e_a3, r_e_tnew) ||
                   hazard(d_rt, d_tuse_rt, r_m_a3, r_m_tnew);
        fwd_rs_d = sel_d(d_rs, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
        fwd_rt_d = sel_d(d_rt, r_e_a3, r_e_tnew, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
        // E-stage operands: no younger-than-M producer exists, so pass an empty E slot.
        fwd_rs_e = sel_d(r_e_rs, '0, T_ZERO, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
        fwd_rt_e = sel_d(r_e_rt, '0, T_ZERO, r_m_a3, r_m_tnew, r_w_a3, r_w_tnew);
    end

    assign stall = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_a3   <= '0;
            r_e_tnew <= '0;
            r_e_rs   <= '0;
            r_e_rt   <= '0;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
            r_w_a3   <= '0;
            r_w_tnew <= '0;
        end else begin
            // Tnew counts cycles to a valid result, so it ages at every stage hop.
            r_w_a3   <= r_m_a3;
            r_w_tnew <= sat_dec(r_m_tnew);
            r_m_a3   <= r_e_a3;
            r_m_tnew <= sat_dec(r_e_tnew);
            if (w_stall) begin
                r_e_a3   <= '0;
                r_e_tnew <= '0;
                r_e_rs   <= '0;
                r_e_rt   <= '0;
            end else begin
                r_e_a3   <= d_a3;
                r_e_tnew <= sat_dec(d_tnew);
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PCNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + {{(PCNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed self-checking bench for hazard_scheduler.
module tb_hazard_scheduler;

    logic        clk;
    logic        rst_n;
    logic [4:0]  d_rs, d_rt, d_a3;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic [31:0] stall_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_stalls = 0;

    hazard_scheduler #(.RA_W(5), .T_W(2), .PCNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_a3(d_a3), .d_tnew(d_tnew),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                         input logic [4:0] a3, input logic [1:0] tnew);
        d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt; d_a3 = a3; d_tnew = tnew;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic flush;
        set_d(0, 0, 3, 3, 0, 0);
        for (int i = 0; i < 3; i++) tick();
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef HAZ_PERF_CNT_EN
        return exp_stalls;
`else
        return 32'd0;
`endif
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        set_d(5'd9, 5'd9, 0, 0, 5'd9, 3);
        #2;
        checks++;
        if ({stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 9'd0) begin
            failures++; $display("FAIL reset_outputs got=%b want=0", {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e});
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++; $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
        end
        tick(); tick();
        rst_n = 1'b1;
        exp_stalls = 0;
        sample();
        checks++;
        if ({stall, fwd_rs_d, fwd_rt_d} !== 5'd0) begin
            failures++; $display("FAIL reset_first_cycle got=%b want=0", {stall, fwd_rs_d, fwd_rt_d});
        end
        flush();
    endtask

    task automatic test_alu_fwd;
        set_d(0, 0, 3, 3, 5'd8, 2);
        tick();
        set_d(5'd8, 0, 1, 3, 5'd10, 2);
        sample();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b want=0", stall); end
        checks++;
        if (fwd_rs_d !== 2'd0) begin failures++; $display("FAIL alu_fwd_rs_d got=%0d want=0", fwd_rs_d); end
        tick();
        set_d(0, 0, 3, 3, 0, 0);
        sample();
        checks++;
        if (fwd_rs_e !== 2'd2) begin failures++; $display("FAIL alu_fwd_rs_e got=%0d want=2", fwd_rs_e); end
        flush();
    endtask

    task automatic test_load_use_branch;
        set_d(0, 0, 3, 3, 5'd9, 3);
        tick();
        set_d(5'd9, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            sample();
            checks++;
            if (stall !== 1'b1 || fwd_rs_d !== 2'd0) begin
                failures++; $display("FAIL lw_beq_stall%0d got=%b/%0d want=1/0", i, stall, fwd_rs_d);
            end
            tick();
            exp_stalls++;
        end
        sample();
        checks++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd3) begin
            failures++; $display("FAIL lw_beq_release got=%b/%0d want=0/3", stall, fwd_rs_d);
        end
        checks++;
        if (stall_cnt !== exp_cnt()) begin
            failures++; $display("FAIL lw_beq_cnt got=%0d want=%0d", stall_cnt, exp_cnt());
        end
        flush();
    endtask

    task automatic test_store;
        set_d(0, 0, 3, 3, 5'd9, 3);
        tick();
        set_d(0, 5'd9, 1, 2, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL sw_stall got=%b want=0", stall); end
        tick();
        set_d(0, 0, 3, 3, 0, 0);
        sample();
        checks++;
        if (fwd_rt_e !== 2'd0) begin failures++; $display("FAIL sw_fwd_rt_e_m_busy got=%0d want=0", fwd_rt_e); end
        flush();
    endtask

    task automatic test_jal_jr;
        set_d(0, 0, 3, 3, 5'd31, 1);
        tick();
        set_d(5'd31, 0, 0, 3, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd1) begin
            failures++; $display("FAIL jal_jr got=%b/%0d want=0/1", stall, fwd_rs_d);
        end
        flush();
    endtask

    task automatic test_zero_reg;
        set_d(0, 0, 3, 3, 5'd0, 2);
        tick();
        set_d(0, 0, 0, 0, 0, 0);
        sample();
        checks++;
        if ({stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 9'd0) begin
            failures++; $display("FAIL zero_reg got=%b want=0", {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e});
        end
        flush();
    endtask

    task automatic test_tuse_unused;
        set_d(0, 0, 3, 3, 5'd12, 3);
        tick();
        set_d(5'd12, 5'd12, 3, 3, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL tuse_unused got=%b want=0", stall); end
        flush();
    endtask

    task automatic test_both_operands;
        set_d(0, 0, 3, 3, 5'd7, 3);
        tick();
        set_d(5'd7, 5'd7, 0, 0, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b1 || fwd_rs_d !== 2'd0 || fwd_rt_d !== 2'd0) begin
            failures++; $display("FAIL both_stall got=%b/%0d/%0d want=1/0/0", stall, fwd_rs_d, fwd_rt_d);
        end
        tick(); exp_stalls++;
        tick(); exp_stalls++;
        sample();
        checks++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd3 || fwd_rt_d !== 2'd3) begin
            failures++; $display("FAIL both_release got=%b/%0d/%0d want=0/3/3", stall, fwd_rs_d, fwd_rt_d);
        end
        checks++;
        if (stall_cnt !== exp_cnt()) begin
            failures++; $display("FAIL both_cnt got=%0d want=%0d", stall_cnt, exp_cnt());
        end
        flush();
    endtask

    task automatic test_priority_reset;
        set_d(0, 0, 3, 3, 5'd5, 1);
        tick();
        set_d(0, 0, 3, 3, 5'd5, 2);
        tick();
        set_d(5'd5, 0, 0, 3, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b1 || fwd_rs_d !== 2'd0) begin
            failures++; $display("FAIL prio_stall got=%b/%0d want=1/0", stall, fwd_rs_d);
        end
        tick(); exp_stalls++;
        sample();
        checks++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd2) begin
            failures++; $display("FAIL prio_release got=%b/%0d want=0/2", stall, fwd_rs_d);
        end
        flush();
        set_d(0, 0, 3, 3, 5'd5, 1);
        tick();
        set_d(0, 0, 3, 3, 5'd5, 2);
        tick();
        set_d(5'd5, 0, 0, 3, 0, 0);
        sample();
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL prio_restall got=%b want=1", stall); end
        rst_n = 1'b0;
        exp_stalls = 0;
        #1;
        checks++;
        if (stall !== 1'b0 || fwd_rs_d !== 2'd0) begin
            failures++; $display("FAIL midstall_reset got=%b/%0d want=0/0", stall, fwd_rs_d);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++; $display("FAIL midstall_cnt got=%0d want=0", stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        sample();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%b want=0", stall); end
        flush();
    endtask

    initial begin
        rst_n = 1'b0;
        set_d(0, 0, 3, 3, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use_branch();
        test_store();
        test_jal_jr();
        test_zero_reg();
        test_tuse_unused();
        test_both_operands();
        test_priority_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
